// File: rtl/serial_cmp_pkg.sv
// Shared types for the serial compare arbiter and its MSB-first comparison core.
package serial_cmp_pkg;

    // Arbiter sequencing states
    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_SHIFT = 2'd1,
        ARB_DONE  = 2'd2
    } arb_state_e;

    // Comparison core decision states
    typedef enum logic [1:0] {
        CMP_EQUAL       = 2'd0,
        CMP_A_LESS_B    = 2'd1,
        CMP_A_GREATER_B = 2'd2
    } cmp_state_e;

    // Bit-index counter width for a W-bit operand (never narrower than 1)
    function automatic int unsigned cnt_width(input int unsigned w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction

endpackage

// File: rtl/serial_compare_msb_core.sv
// MSB-first serial magnitude comparator: latches the first differing bit.
module serial_compare_msb_core
    import serial_cmp_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic bit_valid,
    input  logic a,
    input  logic b,
    output logic a_less_b,
    output logic a_eq_b,
    output logic a_greater_b
);

    cmp_state_e r_state;

    // Decision register: once a difference is seen the state is held until clear
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= CMP_EQUAL;
        end else if (clear) begin
            r_state <= CMP_EQUAL;
        end else if (bit_valid && (r_state == CMP_EQUAL) && (a != b)) begin
            r_state <= a ? CMP_A_GREATER_B : CMP_A_LESS_B;
        end
    end

    // One-hot decode of the decision register
    assign a_less_b    = (r_state == CMP_A_LESS_B);
    assign a_eq_b      = (r_state == CMP_EQUAL);
    assign a_greater_b = (r_state == CMP_A_GREATER_B);

endmodule

// File: rtl/serial_compare_arbiter.sv
// Two-requester round-robin front end feeding a serial MSB-first comparator.
module serial_compare_arbiter
    import serial_cmp_pkg::*;
#(
    parameter int unsigned W          = 8,
    parameter bit          EARLY_EXIT = 1'b1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         req0_valid,
    output logic         req0_ready,
    input  logic [W-1:0] req0_a,
    input  logic [W-1:0] req0_b,
    input  logic         req1_valid,
    output logic         req1_ready,
    input  logic [W-1:0] req1_a,
    input  logic [W-1:0] req1_b,
    output logic         res_valid,
    input  logic         res_ready,
    output logic         res_id,
    output logic         res_a_less_b,
    output logic         res_a_eq_b,
    output logic         res_a_greater_b
);

    localparam int unsigned CW = cnt_width(W);

    arb_state_e      r_state;
    logic            r_prio;
    logic            r_id;
    logic            r_res_valid;
    logic [W-1:0]    r_a;
    logic [W-1:0]    r_b;
    logic [CW-1:0]   r_cnt;

    logic            w_grant_id;
    logic            w_accept;
    logic            w_bit_a;
    logic            w_bit_b;
    logic            w_exit;
    logic            w_core_lt;
    logic            w_core_eq;
    logic            w_core_gt;

    // Round-robin pick: r_prio names the requester that wins a tie
    always_comb begin
        w_grant_id = 1'b0;
        if (req0_valid && req1_valid) begin
            w_grant_id = r_prio;
        end else if (req1_valid) begin
            w_grant_id = 1'b1;
        end
    end

    // Handshake only in IDLE; rst gating keeps both readys low during reset
    assign w_accept   = rst && (r_state == ARB_IDLE) && (req0_valid || req1_valid);
    assign req0_ready = w_accept && !w_grant_id;
    assign req1_ready = w_accept &&  w_grant_id;

    // Current bit pair presented to the core and the SHIFT exit decision
    assign w_bit_a = r_a[r_cnt];
    assign w_bit_b = r_b[r_cnt];
    assign w_exit  = (r_cnt == '0) || (EARLY_EXIT && (w_bit_a != w_bit_b));

    // Sequencer: accept, shift MSB first, then hold the result until taken
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= ARB_IDLE;
            r_prio      <= 1'b0;
            r_id        <= 1'b0;
            r_res_valid <= 1'b0;
            r_a         <= '0;
            r_b         <= '0;
            r_cnt       <= '0;
        end else begin
            case (r_state)
                ARB_IDLE: begin
                    if (w_accept) begin
                        r_a     <= w_grant_id ? req1_a : req0_a;
                        r_b     <= w_grant_id ? req1_b : req0_b;
                        r_cnt   <= CW'(W - 1);
                        r_id    <= w_grant_id;
                        r_prio  <= !w_grant_id;
                        r_state <= ARB_SHIFT;
                    end
                end
                ARB_SHIFT: begin
                    if (w_exit) begin
                        r_state     <= ARB_DONE;
                        r_res_valid <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt - CW'(1);
                    end
                end
                ARB_DONE: begin
                    if (res_ready) begin
                        r_state     <= ARB_IDLE;
                        r_res_valid <= 1'b0;
                    end
                end
                default: begin
                    r_state     <= ARB_IDLE;
                    r_res_valid <= 1'b0;
                end
            endcase
        end
    end

    // Comparison core; cleared on the grant cycle, fed one bit per SHIFT cycle
    serial_compare_msb_core u_core (
        .clk         (clk),
        .rst         (rst),
        .clear       (w_accept),
        .bit_valid   (r_state == ARB_SHIFT),
        .a           (w_bit_a),
        .b           (w_bit_b),
        .a_less_b    (w_core_lt),
        .a_eq_b      (w_core_eq),
        .a_greater_b (w_core_gt)
    );

    // Core decision is frozen in DONE; mask it to zero whenever no result is offered
    assign res_valid       = r_res_valid;
    assign res_id          = r_id;
    assign res_a_less_b    = r_res_valid && w_core_lt;
    assign res_a_eq_b      = r_res_valid && w_core_eq;
    assign res_a_greater_b = r_res_valid && w_core_gt;

endmodule

// File: tb/tb_serial_compare_arbiter.sv
// Directed bench for serial_compare_arbiter (W=8), early-exit and full-shift builds.
module tb_serial_compare_arbiter;

    localparam int unsigned W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         req0_valid, req1_valid;
    logic         req0_ready, req1_ready;
    logic [W-1:0] req0_a, req0_b, req1_a, req1_b;
    logic         res_valid, res_ready, res_id;
    logic         res_a_less_b, res_a_eq_b, res_a_greater_b;

    logic         e_req1_valid;
    logic         e_req0_ready, e_req1_ready;
    logic         e_res_valid, e_res_id;
    logic         e_lt, e_eq, e_gt;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    serial_compare_arbiter #(.W(W), .EARLY_EXIT(1'b1)) u_dut (
        .clk             (clk),
        .rst             (rst),
        .req0_valid      (req0_valid),
        .req0_ready      (req0_ready),
        .req0_a          (req0_a),
        .req0_b          (req0_b),
        .req1_valid      (req1_valid),
        .req1_ready      (req1_ready),
        .req1_a          (req1_a),
        .req1_b          (req1_b),
        .res_valid       (res_valid),
        .res_ready       (res_ready),
        .res_id          (res_id),
        .res_a_less_b    (res_a_less_b),
        .res_a_eq_b      (res_a_eq_b),
        .res_a_greater_b (res_a_greater_b)
    );

    serial_compare_arbiter #(.W(W), .EARLY_EXIT(1'b0)) u_dut_full (
        .clk             (clk),
        .rst             (rst),
        .req0_valid      (1'b0),
        .req0_ready      (e_req0_ready),
        .req0_a          (req0_a),
        .req0_b          (req0_b),
        .req1_valid      (e_req1_valid),
        .req1_ready      (e_req1_ready),
        .req1_a          (req1_a),
        .req1_b          (req1_b),
        .res_valid       (e_res_valid),
        .res_ready       (res_ready),
        .res_id          (e_res_id),
        .res_a_less_b    (e_lt),
        .res_a_eq_b      (e_eq),
        .res_a_greater_b (e_gt)
    );

    task automatic test_reset();
        rst = 1'b0; req0_valid = 1'b1; req1_valid = 1'b0; e_req1_valid = 1'b0; res_ready = 1'b1;
        req0_a = '0; req0_b = '0; req1_a = '0; req1_b = '0;
        @(negedge clk);
        vectors++;
        if ({res_valid, res_a_less_b, res_a_eq_b, res_a_greater_b, res_id} !== 5'b0) begin
            miscompares++;
            $display("FAIL reset_outputs: got %b expected 00000",
                     {res_valid, res_a_less_b, res_a_eq_b, res_a_greater_b, res_id});
        end
        vectors++;
        if ({req0_ready, req1_ready} !== 2'b00) begin
            miscompares++;
            $display("FAIL reset_ready: got %b expected 00", {req0_ready, req1_ready});
        end
        req0_valid = 1'b0;
        @(negedge clk); rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_equal();
        logic exp_v;
        req0_a = 8'h5A; req0_b = 8'h5A; res_ready = 1'b1; req0_valid = 1'b1;
        #1;
        vectors++;
        if ({req0_ready, req1_ready} !== 2'b10) begin
            miscompares++;
            $display("FAIL eq_grant: got %b expected 10", {req0_ready, req1_ready});
        end
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            if (c == 1) req0_valid = 1'b0;
            exp_v = (c == 9);
            vectors++;
            if (res_valid !== exp_v) begin
                miscompares++;
                $display("FAIL eq_res_valid cycle %0d: got %b expected %b", c, res_valid, exp_v);
            end
            if (c == 9) begin
                vectors++;
                if ({res_a_less_b, res_a_eq_b, res_a_greater_b, res_id} !== 4'b0100) begin
                    miscompares++;
                    $display("FAIL eq_result: got %b expected 0100",
                             {res_a_less_b, res_a_eq_b, res_a_greater_b, res_id});
                end
            end
            if (c == 10) begin
                vectors++;
                if ({res_a_less_b, res_a_eq_b, res_a_greater_b} !== 3'b000) begin
                    miscompares++;
                    $display("FAIL eq_flags_idle: got %b expected 000",
                             {res_a_less_b, res_a_eq_b, res_a_greater_b});
                end
            end
        end
    endtask

    task automatic test_early_exit();
        logic exp_v;
        req1_a = 8'h80; req1_b = 8'h7F; req1_valid = 1'b1;
        #1;
        vectors++;
        if ({req0_ready, req1_ready} !== 2'b01) begin
            miscompares++;
            $display("FAIL ee_grant: got %b expected 01", {req0_ready, req1_ready});
        end
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            if (c == 1) req1_valid = 1'b0;
            exp_v = (c == 2);
            vectors++;
            if (res_valid !== exp_v) begin
                miscompares++;
                $display("FAIL ee_res_valid cycle %0d: got %b expected %b", c, res_valid, exp_v);
            end
            if (c == 2) begin
                vectors++;
                if ({res_a_less_b, res_a_eq_b, res_a_greater_b, res_id} !== 4'b0011) begin
                    miscompares++;
                    $display("FAIL ee_result: got %b expected 0011",
                             {res_a_less_b, res_a_eq_b, res_a_greater_b, res_id});
                end
            end
        end
        // Same operands through the build that always shifts all bits
        e_req1_valid = 1'b1;
        #1;
        vectors++;
        if ({e_req0_ready, e_req1_ready} !== 2'b01) begin
            miscompares++;
            $display("FAIL full_grant: got %b expected 01", {e_req0_ready, e_req1_ready});
        end
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            if (c == 1) e_req1_valid = 1'b0;
            exp_v = (c == 9);
            vectors++;
            if (e_res_valid !== exp_v) begin
                miscompares++;
                $display("FAIL full_res_valid cycle %0d: got %b expected %b", c, e_res_valid, exp_v);
            end
            if (c == 9) begin
                vectors++;
                if ({e_lt, e_eq, e_gt, e_res_id} !== 4'b0011) begin
                    miscompares++;
                    $display("FAIL full_result: got %b expected 0011", {e_lt, e_eq, e_gt, e_res_id});
                end
            end
        end
    endtask

    task automatic test_round_robin();
        logic exp_v;
        rst = 1'b0;
        @(negedge clk); rst = 1'b1;
        @(negedge clk);
        req0_a = 8'h01; req0_b = 8'h02; req1_a = 8'h03; req1_b = 8'h03;
        req0_valid = 1'b1; req1_valid = 1'b1; res_ready = 1'b1;
        #1;
        vectors++;
        if ({req0_ready, req1_ready} !== 2'b10) begin
            miscompares++;
            $display("FAIL rr_first_grant: got %b expected 10", {req0_ready, req1_ready});
        end
        for (int c = 1; c <= 19; c++) begin
            @(negedge clk);
            if (c == 1)  req0_valid = 1'b0;
            if (c == 10) req1_valid = 1'b0;
            exp_v = (c == 8) || (c == 18);
            vectors++;
            if (res_valid !== exp_v) begin
                miscompares++;
                $display("FAIL rr_res_valid cycle %0d: got %b expected %b", c, res_valid, exp_v);
            end
            if (c == 3) begin
                vectors++;
                if ({req0_ready, req1_ready} !== 2'b00) begin
                    miscompares++;
                    $display("FAIL rr_ready_in_shift: got %b expected 00", {req0_ready, req1_ready});
                end
            end
            if (c == 8) begin
                vectors++;
                if ({res_a_less_b, res_a_eq_b, res_a_greater_b, res_id} !== 4'b1000) begin
                    miscompares++;
                    $display("FAIL rr_result0: got %b expected 1000",
                             {res_a_less_b, res_a_eq_b, res_a_greater_b, res_id});
                end
            end
            if (c == 9) begin
                vectors++;
                if ({req0_ready, req1_ready} !== 2'b01) begin
                    miscompares++;
                    $display("FAIL rr_second_grant: got %b expected 01", {req0_ready, req1_ready});
                end
            end
            if (c == 18) begin
                vectors++;
                if ({res_a_less_b, res_a_eq_b, res_a_greater_b, res_id} !== 4'b0101) begin
                    miscompares++;
                    $display("FAIL rr_result1: got %b expected 0101",
                             {res_a_less_b, res_a_eq_b, res_a_greater_b, res_id});
                end
            end
        end
        // Pointer now favours req0; withdraw before the edge so nothing is accepted
        req0_a = 8'h10; req0_b = 8'h20; req0_valid = 1'b1; req1_valid = 1'b1;
        #1;
        vectors++;
        if ({req0_ready, req1_ready} !== 2'b10) begin
            miscompares++;
            $display("FAIL rr_pointer_back: got %b expected 10", {req0_ready, req1_ready});
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_backpressure();
        logic exp_v;
        req0_a = 8'h33; req0_b = 8'h30; req0_valid = 1'b1; res_ready = 1'b0;
        #1;
        vectors++;
        if ({req0_ready, req1_ready} !== 2'b10) begin
            miscompares++;
            $display("FAIL bp_grant: got %b expected 10", {req0_ready, req1_ready});
        end
        for (int c = 1; c <= 14; c++) begin
            @(negedge clk);
            if (c == 1) begin
                req0_valid = 1'b0; req1_valid = 1'b1; req1_a = 8'hAA; req1_b = 8'h55;
            end
            exp_v = (c >= 8) && (c <= 13);
            vectors++;
            if (res_valid !== exp_v) begin
                miscompares++;
                $display("FAIL bp_res_valid cycle %0d: got %b expected %b", c, res_valid, exp_v);
            end
            if (exp_v) begin
                vectors++;
                if ({res_a_less_b, res_a_eq_b, res_a_greater_b, res_id, req0_ready, req1_ready} !== 6'b001000) begin
                    miscompares++;
                    $display("FAIL bp_hold cycle %0d: got %b expected 001000", c,
                             {res_a_less_b, res_a_eq_b, res_a_greater_b, res_id, req0_ready, req1_ready});
                end
            end
            if (c == 13) res_ready = 1'b1;
            if (c == 14) begin
                vectors++;
                if ({req0_ready, req1_ready} !== 2'b01) begin
                    miscompares++;
                    $display("FAIL bp_idle_after_release: got %b expected 01", {req0_ready, req1_ready});
                end
                req1_valid = 1'b0;
            end
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        logic exp_v;
        req0_a = 8'h12; req0_b = 8'h12; req0_valid = 1'b1; res_ready = 1'b1;
        #1;
        vectors++;
        if ({req0_ready, req1_ready} !== 2'b10) begin
            miscompares++;
            $display("FAIL rm_grant: got %b expected 10", {req0_ready, req1_ready});
        end
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            if (c == 1) req0_valid = 1'b0;
        end
        #2; rst = 1'b0; req1_valid = 1'b1;
        #1;
        vectors++;
        if ({res_valid, res_a_less_b, res_a_eq_b, res_a_greater_b, res_id, req0_ready, req1_ready} !== 7'b0) begin
            miscompares++;
            $display("FAIL rm_async_reset: got %b expected 0000000",
                     {res_valid, res_a_less_b, res_a_eq_b, res_a_greater_b, res_id, req0_ready, req1_ready});
        end
        @(negedge clk);
        @(negedge clk); rst = 1'b1; req1_valid = 1'b0;
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            vectors++;
            if ({res_valid, res_a_less_b, res_a_eq_b, res_a_greater_b} !== 4'b0) begin
                miscompares++;
                $display("FAIL rm_no_stale_result cycle %0d: got %b expected 0000", c,
                         {res_valid, res_a_less_b, res_a_eq_b, res_a_greater_b});
            end
        end
        req1_a = 8'h01; req1_b = 8'h00; req1_valid = 1'b1;
        #1;
        vectors++;
        if ({req0_ready, req1_ready} !== 2'b01) begin
            miscompares++;
            $display("FAIL rm_new_grant: got %b expected 01", {req0_ready, req1_ready});
        end
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            if (c == 1) req1_valid = 1'b0;
            exp_v = (c == 9);
            vectors++;
            if (res_valid !== exp_v) begin
                miscompares++;
                $display("FAIL rm_res_valid cycle %0d: got %b expected %b", c, res_valid, exp_v);
            end
            if (c == 9) begin
                vectors++;
                if ({res_a_less_b, res_a_eq_b, res_a_greater_b, res_id} !== 4'b0011) begin
                    miscompares++;
                    $display("FAIL rm_result: got %b expected 0011",
                             {res_a_less_b, res_a_eq_b, res_a_greater_b, res_id});
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_equal();
        test_early_exit();
        test_round_robin();
        test_backpressure();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/serial_compare_arbiter.md
SERIAL_COMPARE_ARBITER -- requirements
Module: serial_compare_arbiter

Interface
REQ-001 Parameter W, 8, operand width in bits (W >= 2).
REQ-002 Parameter EARLY_EXIT, 1, 1 = stop shifting at the first differing bit; 0 = always shift all W bits.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-low.
REQ-005 req0_valid / req1_valid  input  1 each  requester has an operand pair pending.
REQ-006 req0_ready / req1_ready  output  1 each  operand pair accepted this cycle.
REQ-007 req0_a, req0_b / req1_a, req1_b  input  W each  parallel operands.
REQ-008 res_valid  output  1  result available.
REQ-009 res_ready  input  1  consumer takes the result.
REQ-010 res_id  output  1  requester that owns the result (0 or 1).
REQ-011 res_a_less_b / res_a_eq_b / res_a_greater_b  output  1 each  one-hot comparison result.

Function
REQ-012 FSM states are IDLE, SHIFT and DONE.
REQ-013 IDLE: if any reqN_valid, grant exactly one requester and assert its reqN_ready combinationally in the same cycle.
- Capture its a/b into shift registers and load bit counter = W-1.
- Go to SHIFT.
REQ-014 Arbitration is round-robin. With both valid, grant the requester not granted last. After reset, req0 has priority.
REQ-015 reqN_ready is high only in IDLE, only for the granted requester, and at most one ready is high per cycle.
REQ-016 Requesters hold valid and data stable until ready. The block does not sample operands outside the handshake cycle.
REQ-017 SHIFT: each cycle present operand bit [counter], MSB first, to the core and decrement the counter.
REQ-018 SHIFT exit condition:
- Go to DONE after the cycle that presents bit 0.
- If EARLY_EXIT=1, also go to DONE after the first cycle whose presented bits differ.
REQ-019 Latency, with acceptance in cycle 0:
- res_valid rises in cycle W+1 when no early exit occurs.
- With early exit on bit index k, res_valid rises in cycle W-k+1.
REQ-020 DONE: res_valid=1. res_id and the result flags are registered and stay stable until the res_ready handshake.
REQ-021 In DONE with res_ready=1, return to IDLE. No new grant is made in that same cycle.
REQ-022 Exactly one result flag is high while res_valid=1. All result flags are 0 while res_valid=0.
REQ-023 The core decides the result: the first differing bit, MSB first, sets less or greater; if no bits differ, the result is eq.

Reset
REQ-024 While rst=0, and asynchronously on its assertion:
- state=IDLE, priority pointer=req0.
- res_valid=0, all result flags=0, res_id=0, both ready=0.
- Shift registers and counter=0; core state=equal.
REQ-025 Reset asserted during SHIFT or DONE discards the transaction. No result is emitted for it after reset release.

Structure
REQ-026 Package serial_cmp_pkg holds the arbiter state enum (IDLE/SHIFT/DONE) and the comparator state enum (equal/a_less_b/a_greater_b).
REQ-027 Sub-module serial_compare_msb_core holds the MSB-first comparison FSM.
- Ports: clk, rst, clear, bit_valid, a, b, a_less_b, a_eq_b, a_greater_b.
- clear is pulsed on the grant cycle.
- It stays in the decided state once a difference has been seen.
REQ-028 Target size is 120-400 lines of RTL including the core.

Verification (W=8)
REQ-029 req0 a=0x5A b=0x5A, EARLY_EXIT=1, res_ready=1 -> res_a_eq_b=1, res_id=0, res_valid in cycle 9 only.
REQ-030 req1 a=0x80 b=0x7F, EARLY_EXIT=1 -> res_a_greater_b=1, res_id=1, res_valid in cycle 2. With EARLY_EXIT=0 the same result arrives in cycle 9.
REQ-031 Both valid right after reset, req0 (0x01,0x02) and req1 (0x03,0x03) -> req0 granted first with less; req1 granted next with eq; then the pointer favours req0.
REQ-032 res_ready held 0 for 5 cycles in DONE -> result and res_id stable, both ready=0; release -> IDLE next cycle.
REQ-033 rst asserted in the 3rd SHIFT cycle -> all outputs 0 immediately. After release, no result appears until a new handshake.
